// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage pipeline.
// Holds the ID->EX pipeline register, computes the ALU result or effective
// address, drives the data SRAM request, and runs a 32-cycle radix-2
// restoring divider that writes HI (remainder) and LO (quotient).
// Ports:
//   clk, rst (sync, active-high), flush, stall[5:0] (bit2 = EX hold, bit3 = MEM hold)
//   id_*            : decoded instruction fields from ID
//   ex_to_mem_bus   : 81-bit payload to MEM
//   data_sram_*     : data memory request
//   stallreq_for_ex : pipeline hold request while a divide is in flight
//   hi_we/lo_we/hi_wdata/lo_wdata : HI/LO write port
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [5:0]  stall,
  input  logic [31:0] id_pc,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_src1,
  input  logic [31:0] id_src2,
  input  logic [31:0] id_st_data,
  input  logic [4:0]  id_mem_op,
  input  logic [1:0]  id_div_op,
  input  logic        id_sel_rf_res,
  input  logic        id_rf_we,
  input  logic [4:0]  id_rf_waddr,
  output logic [80:0] ex_to_mem_bus,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic        stallreq_for_ex,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned LAST_IT = 31;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] st_data;
    logic [4:0]      mem_op;
    logic [1:0]      div_op;
    logic            sel_rf_res;
    logic            rf_we;
    logic [4:0]      rf_waddr;
  } ex_reg_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  ex_reg_t ex_q;
  logic    ex_upd;
  logic    stall_unused;

  assign stall_unused = ^{stall[5:4], stall[1:0]};

  // Any non-hold update replaces the EX contents (new instruction or bubble).
  assign ex_upd = rst | flush | ~stall[2] | ~stall[3];

  // EX pipeline register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_q <= '0;
    end else if (stall[2] && !stall[3]) begin
      ex_q <= '0;
    end else if (!stall[2]) begin
      ex_q <= '{pc: id_pc, alu_op: id_alu_op, src1: id_src1, src2: id_src2,
                st_data: id_st_data, mem_op: id_mem_op, div_op: id_div_op,
                sel_rf_res: id_sel_rf_res, rf_we: id_rf_we, rf_waddr: id_rf_waddr};
    end
  end

  // ALU / effective address
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] ex_result;
  logic [4:0]      shamt;

  assign shamt = ex_q.src1[4:0];

  always_comb begin
    alu_res = '0;
    case (ex_q.alu_op)
      4'd0:    alu_res = ex_q.src1 + ex_q.src2;
      4'd1:    alu_res = ex_q.src1 - ex_q.src2;
      4'd2:    alu_res = ex_q.src1 & ex_q.src2;
      4'd3:    alu_res = ex_q.src1 | ex_q.src2;
      4'd4:    alu_res = ex_q.src1 ^ ex_q.src2;
      4'd5:    alu_res = XLEN'($signed(ex_q.src1) < $signed(ex_q.src2));
      4'd6:    alu_res = XLEN'(ex_q.src1 < ex_q.src2);
      4'd7:    alu_res = ex_q.src2 << shamt;
      4'd8:    alu_res = ex_q.src2 >> shamt;
      4'd9:    alu_res = XLEN'($signed(ex_q.src2) >>> shamt);
      4'd10:   alu_res = {ex_q.src2[15:0], 16'b0};
      default: alu_res = '0;
    endcase
    ex_result = alu_res;
    if (ex_q.mem_op != '0)      ex_result = ex_q.src1 + ex_q.src2;
    else if (ex_q.div_op != '0) ex_result = '0;
  end

  // Data SRAM request; misaligned accesses are dropped but mem_op still forwarded.
  logic is_lw, is_lh, is_sw, is_sh, misaligned;

  assign is_lw = ex_q.mem_op[4];
  assign is_lh = ex_q.mem_op[3];
  assign is_sw = ex_q.mem_op[2];
  assign is_sh = ex_q.mem_op[1];

  always_comb begin
    misaligned      = ((is_lw | is_sw) & (ex_result[1:0] != 2'b00)) |
                      ((is_lh | is_sh) & ex_result[0]);
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = ex_result;
    data_sram_wdata = ex_q.st_data;
    if (is_sh) data_sram_wdata = {ex_q.st_data[15:0], ex_q.st_data[15:0]};
    if (!misaligned) begin
      if (is_lw || is_lh) begin
        data_sram_en = 1'b1;
      end else if (is_sw) begin
        data_sram_en  = 1'b1;
        data_sram_wen = 4'b1111;
      end else if (is_sh) begin
        data_sram_en  = 1'b1;
        data_sram_wen = ex_result[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  assign ex_to_mem_bus = {ex_q.mem_op, ex_q.pc, data_sram_en, data_sram_wen,
                          ex_q.sel_rf_res, ex_q.rf_we, ex_q.rf_waddr, ex_result};

  // Divider
  div_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            neg_q_q, neg_r_q;
  logic            fired_q;   // divide in EX already started; blocks a re-run
  logic            is_div, div_start;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] abs_src1, abs_src2;

  assign is_div    = ex_q.div_op[1];
  assign div_start = (state_q == IDLE) && (ex_q.div_op != '0) && !fired_q;
  assign abs_src1  = (is_div && ex_q.src1[31]) ? -ex_q.src1 : ex_q.src1;
  assign abs_src2  = (is_div && ex_q.src2[31]) ? -ex_q.src2 : ex_q.src2;
  assign rem_sh    = {rem_q, quo_q[31]};
  assign diff      = rem_sh - {1'b0, dvs_q};

  // Divider next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_start) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(LAST_IT)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Divider state and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ex_upd)         fired_q <= 1'b0;
      else if (div_start) fired_q <= 1'b1;
      if (div_start) begin
        quo_q   <= abs_src1;
        dvs_q   <= abs_src2;
        rem_q   <= '0;
        cnt_q   <= '0;
        neg_q_q <= is_div & (ex_q.src1[31] ^ ex_q.src2[31]);
        neg_r_q <= is_div & ex_q.src1[31];
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!diff[XLEN]) begin
          rem_q <= diff[XLEN-1:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= rem_sh[XLEN-1:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
      end
    end
  end

  // In IDLE after a finished divide the same instruction must not re-request a hold.
  assign stallreq_for_ex = (ex_q.div_op != '0) && (state_q != DONE) &&
                           !((state_q == IDLE) && fired_q);
  assign hi_we    = (state_q == DONE);
  assign lo_we    = (state_q == DONE);
  assign hi_wdata = (state_q == DONE) ? (neg_r_q ? -rem_q : rem_q) : '0;
  assign lo_wdata = (state_q == DONE) ? (neg_q_q ? -quo_q : quo_q) : '0;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic        clk, rst, flush;
  logic [5:0]  stall;
  logic [31:0] id_pc, id_src1, id_src2, id_st_data;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_mem_op, id_rf_waddr;
  logic [1:0]  id_div_op;
  logic        id_sel_rf_res, id_rf_we;
  logic [80:0] ex_to_mem_bus;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        stallreq_for_ex, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int passed = 0;
  int total  = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_src1(id_src1), .id_src2(id_src2),
    .id_st_data(id_st_data), .id_mem_op(id_mem_op), .id_div_op(id_div_op),
    .id_sel_rf_res(id_sel_rf_res), .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
    .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .stallreq_for_ex(stallreq_for_ex),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [3:0] op,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] st, input logic [4:0] mem,
                        input logic [1:0] dv, input logic we, input logic [4:0] wa);
    id_pc = pc; id_alu_op = op; id_src1 = s1; id_src2 = s2; id_st_data = st;
    id_mem_op = mem; id_div_op = dv; id_sel_rf_res = 1'b0; id_rf_we = we;
    id_rf_waddr = wa;
  endtask

  // Runs a divide already sitting in the ID inputs; returns observed stall length.
  task automatic run_div(output int n, output logic we_early);
    stall = 6'b000000;
    step();
    stall = 6'b001100;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    we_early = 1'b0;
    while (stallreq_for_ex === 1'b1 && n < 100) begin
      n++;
      if (hi_we !== 1'b0 || lo_we !== 1'b0) we_early = 1'b1;
      step();
    end
  endtask

  logic [3:0]  t_op [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
  logic [31:0] t_s1 [11] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'd4, 32'd4, 32'd4, 32'd0, 32'd3};
  logic [31:0] t_s2 [11] = '{32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'd1,
                             32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'h00001234, 32'd4};
  logic [31:0] t_ex [11] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'd1,
                             32'd0, 32'h10, 32'h08000000, 32'hF8000000, 32'h12340000, 32'd0};

  initial begin
    int   n;
    logic we_early, we_seen;

    rst = 1'b1; flush = 1'b0; stall = 6'b0;
    set_id(32'h1111, 4'd0, 32'd9, 32'd9, 32'd9, 5'b0, 2'b0, 1'b1, 5'd7);
    step(); step();
    chk("rst_bus", ex_to_mem_bus, 81'd0);
    chk("rst_sram", {data_sram_en, data_sram_wen}, 5'd0);
    chk("rst_stallreq", stallreq_for_ex, 1'b0);
    chk("rst_hilo_we", {hi_we, lo_we}, 2'b00);

    // add wrap, next-cycle load
    rst = 1'b0;
    set_id(32'h100, 4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'b0, 2'b0, 1'b1, 5'd5);
    step();
    chk("add_bus", ex_to_mem_bus,
        {5'b0, 32'h100, 1'b0, 4'b0, 1'b0, 1'b1, 5'd5, 32'h80000000});
    chk("add_rf_we", ex_to_mem_bus[37], 1'b1);

    for (int i = 0; i < 11; i++) begin
      set_id(32'h200, t_op[i], t_s1[i], t_s2[i], 32'd0, 5'b0, 2'b0, 1'b1, 5'd1);
      step();
      chk($sformatf("alu_op%0d", t_op[i]), ex_to_mem_bus[31:0], t_ex[i]);
    end

    // sh upper half
    set_id(32'h300, 4'd0, 32'h1000, 32'd2, 32'h0000ABCD, 5'b00010, 2'b0, 1'b0, 5'd0);
    step();
    chk("sh_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
        {1'b1, 4'b1100, 32'h1002, 32'hABCDABCD});
    chk("sh_bus", ex_to_mem_bus[80:32], {5'b00010, 32'h300, 1'b1, 4'b1100, 1'b0, 1'b0, 5'd0});

    // misaligned sw dropped, mem_op still forwarded
    set_id(32'h304, 4'd0, 32'h1001, 32'd0, 32'h55, 5'b00100, 2'b0, 1'b0, 5'd0);
    step();
    chk("sw_misal_sram", {data_sram_en, data_sram_wen}, 5'd0);
    chk("sw_misal_bus", {ex_to_mem_bus[80:76], ex_to_mem_bus[43:39]}, {5'b00100, 5'd0});

    set_id(32'h308, 4'd0, 32'h2000, 32'd4, 32'd0, 5'b10000, 2'b0, 1'b1, 5'd2);
    step();
    chk("lw_sram", {data_sram_en, data_sram_wen, data_sram_addr}, {1'b1, 4'b0, 32'h2004});

    // EX bubble and EX/MEM hold
    set_id(32'h400, 4'd0, 32'd1, 32'd2, 32'd0, 5'b0, 2'b0, 1'b1, 5'd3);
    step();
    chk("pre_bubble", ex_to_mem_bus[31:0], 32'd3);
    stall = 6'b000100;
    set_id(32'h404, 4'd0, 32'd10, 32'd20, 32'd0, 5'b0, 2'b0, 1'b1, 5'd4);
    step();
    chk("bubble", ex_to_mem_bus, 81'd0);
    stall = 6'b000000;
    set_id(32'h400, 4'd0, 32'd1, 32'd2, 32'd0, 5'b0, 2'b0, 1'b1, 5'd3);
    step();
    stall = 6'b001100;
    set_id(32'h404, 4'd0, 32'd10, 32'd20, 32'd0, 5'b0, 2'b0, 1'b1, 5'd4);
    step();
    chk("hold", ex_to_mem_bus, {5'b0, 32'h400, 1'b0, 4'b0, 1'b0, 1'b1, 5'd3, 32'd3});

    // signed divide -7 / 2
    set_id(32'h500, 4'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 5'b0, 2'b10, 1'b0, 5'd0);
    run_div(n, we_early);
    chk("div_stall_len", 32'(n), 32'd33);
    chk("div_no_early_we", we_early, 1'b0);
    chk("div_done_we", {hi_we, lo_we, stallreq_for_ex}, 3'b110);
    chk("div_lo", lo_wdata, 32'hFFFFFFFD);
    chk("div_hi", hi_wdata, 32'hFFFFFFFF);
    chk("div_ex_result", ex_to_mem_bus[31:0], 32'd0);
    step();
    chk("div_we_single", {hi_we, lo_we, stallreq_for_ex}, 3'b000);
    step(); step();
    chk("div_no_restart", {hi_we, stallreq_for_ex}, 2'b00);
    stall = 6'b000000;
    step();

    // divu by zero
    set_id(32'h600, 4'd0, 32'd5, 32'd0, 32'd0, 5'b0, 2'b01, 1'b0, 5'd0);
    run_div(n, we_early);
    chk("divu0_stall_len", 32'(n), 32'd33);
    chk("divu0_we", {hi_we, lo_we}, 2'b11);
    chk("divu0_lo", lo_wdata, 32'hFFFFFFFF);
    chk("divu0_hi", hi_wdata, 32'd5);
    stall = 6'b000000;
    step();

    // flush at BUSY cycle 10
    set_id(32'h700, 4'd0, 32'd100, 32'd3, 32'd0, 5'b0, 2'b10, 1'b0, 5'd0);
    step();
    stall = 6'b001100;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    we_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (hi_we !== 1'b0 || lo_we !== 1'b0) we_seen = 1'b1;
    end
    chk("flush_busy_stallreq", stallreq_for_ex, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_stallreq", stallreq_for_ex, 1'b0);
    chk("flush_bus", ex_to_mem_bus, 81'd0);
    stall = 6'b000000;
    for (int k = 0; k < 40; k++) begin
      if (hi_we !== 1'b0 || lo_we !== 1'b0 || stallreq_for_ex !== 1'b0) we_seen = 1'b1;
      step();
    end
    chk("flush_no_we", we_seen, 1'b0);

    // reset mid-divide aborts without write
    set_id(32'h800, 4'd0, 32'd50, 32'd7, 32'd0, 5'b0, 2'b01, 1'b0, 5'd0);
    step();
    stall = 6'b001100;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    chk("rst_mid_div", {ex_to_mem_bus, stallreq_for_ex, hi_we}, 83'd0);
    we_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (hi_we !== 1'b0 || lo_we !== 1'b0) we_seen = 1'b1;
      step();
    end
    chk("rst_no_we", we_seen, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1; single clock, all state on posedge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port flush, input, 1; synchronous pipeline clear.
REQ-004 SHALL have port stall, input, 6; stall[2] = EX hold, stall[3] = MEM hold, 1 = stop.
REQ-005 SHALL have ID-side inputs, latched into the EX register:
- id_pc (32), PC.
- id_alu_op (4), ALU op.
- id_src1 (32) and id_src2 (32), operands already selected.
- id_st_data (32), store data.
- id_mem_op (5), {lw, lh, sw, sh, 0}.
- id_div_op (2), {div, divu}.
- id_sel_rf_res (1), select load result.
- id_rf_we (1), register write enable.
- id_rf_waddr (5), destination register.
REQ-006 SHALL have port ex_to_mem_bus, output, 81 bits, packed as:
- mem_op [80:76]
- pc [75:44]
- data_ram_en [43]
- data_ram_wen [42:39]
- sel_rf_res [38]
- rf_we [37]
- rf_waddr [36:32]
- ex_result [31:0]
REQ-007 SHALL have data SRAM outputs data_sram_en (1), data_sram_wen (4), data_sram_addr (32), data_sram_wdata (32).
REQ-008 SHALL have port stallreq_for_ex, output, 1; requests a pipeline hold while the divider is busy.
REQ-009 SHALL have outputs hi_we (1), lo_we (1), hi_wdata (32), lo_wdata (32).

Function
REQ-010 SHALL update the EX register each clock by the first matching rule:
- rst or flush: clear to 0.
- stall[2]=1 and stall[3]=0: clear to 0 (bubble).
- stall[2]=0: load ID inputs.
- otherwise: hold.
REQ-011 SHALL compute ex_result combinationally from the registered operands, alu_op 0–10 = add, sub, and, or, xor, slt, sltu, sll, srl, sra, lui; other codes yield 0.
- Shift amount = src1[4:0], value = src2.
- lui result = {src2[15:0], 16'b0}.
- add/sub wrap modulo 2^32 (no overflow trap).
REQ-012 SHALL present ex_result as the effective address (src1+src2) whenever mem_op is non-zero.
REQ-013 SHALL drive the SRAM port combinationally:
- lw/lh: en=1, wen=0000.
- sw: en=1, wen=1111, wdata=st_data.
- sh: en=1, wen=0011 if addr[1]=0 else 1100, wdata={st_data[15:0], st_data[15:0]}.
- no mem_op: en=0, wen=0.
REQ-014 SHALL treat misaligned accesses (lw/sw with addr[1:0]≠0; lh/sh with addr[0]=1) as no-access: en=0, wen=0; the bus still forwards mem_op.
REQ-015 SHALL copy data_ram_en and data_ram_wen into ex_to_mem_bus with the same values as the SRAM port.
REQ-016 SHALL implement a radix-2 restoring divider FSM with states IDLE, BUSY, DONE.
REQ-017 SHALL handle IDLE as follows: if div_op≠0, latch |dividend| and |divisor| (divu: raw values), set count=0, go to BUSY.
REQ-018 SHALL handle BUSY as one quotient bit per cycle, count increments, and exit to DONE after count reaches 31 (32 BUSY cycles).
REQ-019 SHALL handle DONE as follows:
- Assert hi_we=lo_we=1 for exactly one cycle, then go to IDLE.
- Signed div: quotient negated if operand signs differ; remainder takes the dividend's sign.
- hi_wdata = remainder, lo_wdata = quotient.
REQ-020 SHALL assert stallreq_for_ex combinationally while div_op≠0 and state≠DONE; it is 0 in DONE, so the divide retires on that cycle.
REQ-021 SHALL give a divide latched into EX at cycle T: stallreq high T..T+32, DONE and hi/lo write at T+33.
REQ-022 SHALL on divide by zero produce quotient 32'hFFFFFFFF (divu) or the sign-adjusted all-ones (div) and remainder = dividend, with no exception.
REQ-023 SHALL drive ex_result=0 and rf_we from the register (decoder clears it) for div ops.
REQ-024 SHALL on flush during BUSY return to IDLE next cycle, with no hi/lo write and stallreq low.
REQ-025 SHALL, in the cycle after a completed divide, leave the FSM in IDLE while the EX register holds no new instruction, and shall not restart the same divide (DONE→IDLE only re-arms when the EX register reloads).

Reset
REQ-026 SHALL on rst set: EX register=0, FSM=IDLE, count=0, all outputs 0 (ex_to_mem_bus=0, data_sram_en/wen=0, stallreq=0, hi/lo_we=0).
REQ-027 SHALL have rst take priority over flush and stall; rst asserted mid-divide aborts it with no hi/lo write.

Verification
REQ-028 SHALL cover add, src1=32'h7FFFFFFF, src2=1 -> ex_result=32'h80000000, bus[37]=rf_we, next-cycle load.
REQ-029 SHALL cover sh with addr=32'h1002, st_data=32'h0000ABCD -> en=1, wen=1100, wdata=32'hABCDABCD.
REQ-030 SHALL cover div with src1=-7, src2=2 -> stallreq high 33 cycles; at DONE lo_wdata=32'hFFFFFFFD, hi_wdata=32'hFFFFFFFF, single-cycle we.
REQ-031 SHALL cover divu with src2=0, src1=5 -> lo_wdata=32'hFFFFFFFF, hi_wdata=5.
REQ-032 SHALL cover stall=6'b000100 -> ex_to_mem_bus=0 next cycle; stall=6'b001100 -> register held unchanged.
REQ-033 SHALL cover flush at BUSY cycle 10 -> IDLE next cycle, hi_we/lo_we never assert, stallreq=0.
